// File: rtl/conv_encoder_r12_if.sv
// Serial bit in / code symbol out bundle for the rate-1/2 convolutional encoder.
interface conv_encoder_r12_if;
  logic       in;
  logic [1:0] out;

  modport master (output in, input  out);
  modport slave  (input  in, output out);
endinterface

// File: rtl/conv_encoder_r12.sv
// Rate-1/2 feed-forward convolutional encoder: one data bit in, one registered
// 2-bit symbol out per clock. Default K=3 with generators 7/5 octal.
module conv_encoder_r12 #(
  parameter int unsigned K  = 3,        // constraint length, legal range 2..9
  parameter logic [K-1:0] G0 = 3'b111,  // out[1] taps; MSB = current input
  parameter logic [K-1:0] G1 = 3'b101   // out[0] taps; LSB = oldest memory bit
) (
  input  logic                clk,
  input  logic                reset,
  conv_encoder_r12_if.slave   enc
);

  localparam int unsigned SR_W = K - 1;

  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_nxt_c;
  logic [K-1:0]    taps_c;
  logic            c0_c;
  logic            c1_c;

  // Tap vector and parity; dropping the LSB of taps is the shift, valid down to K=2.
  always_comb begin
    taps_c   = {enc.in, sr};
    c0_c     = ^(taps_c & G0);
    c1_c     = ^(taps_c & G1);
    sr_nxt_c = SR_W'(taps_c >> 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      enc.out <= 2'b00;
    end else begin
      sr      <= sr_nxt_c;
      enc.out <= {c0_c, c1_c};
    end
  end

endmodule

// File: tb/tb_conv_encoder_r12.sv
// Directed and model-based checks of conv_encoder_r12 for K=3 (7/5) and K=4 (17/13).
module tb_conv_encoder_r12;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [8:0] hist;  // hist[j] = input bit j cycles ago, hist[0] = newest

  conv_encoder_r12_if bus3 ();
  conv_encoder_r12_if bus4 ();

  conv_encoder_r12 u_k3 (
    .clk   (clk),
    .reset (reset),
    .enc   (bus3.slave)
  );

  conv_encoder_r12 #(.K(4), .G0(4'b1111), .G1(4'b1011)) u_k4 (
    .clk   (clk),
    .reset (reset),
    .enc   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model(input int k, input logic [8:0] g0,
                                       input logic [8:0] g1, input logic [8:0] h);
    logic a, b;
    a = 1'b0;
    b = 1'b0;
    for (int j = 0; j < k; j++) begin
      a = a ^ (g0[k-1-j] & h[j]);
      b = b ^ (g1[k-1-j] & h[j]);
    end
    return {a, b};
  endfunction

  // Drive one bit (away from the edge), clock it, then check the K=4 instance vs model.
  task automatic step(input logic b);
    bus3.in = b;
    bus4.in = b;
    hist = {hist[7:0], b};
    @(posedge clk);
    #1;
    chk("k4_model", 32'(bus4.out), 32'(model(4, 9'b1111, 9'b1011, hist)));
  endtask

  logic [8:0] ref_in;
  logic [1:0] ref_out [9];
  logic [4:0] imp_in;
  logic [1:0] imp_out [5];
  logic       rb;

  initial begin
    ref_in  = 9'b000101110;  // bit i = i-th input: 0,1,1,1,0,1,0,0,0
    ref_out = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
    imp_in  = 5'b00001;
    imp_out = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00};

    reset   = 1'b0;
    bus3.in = 1'b0;
    bus4.in = 1'b0;
    hist    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_k3", 32'(bus3.out), 32'd0);
    chk("rst_sr_k3",  32'(u_k3.sr),  32'd0);
    chk("rst_out_k4", 32'(bus4.out), 32'd0);
    reset = 1'b1;

    // Reference stream from the all-zero state
    for (int i = 0; i < 9; i++) begin
      step(ref_in[i]);
      chk($sformatf("ref_%0d", i), 32'(bus3.out), 32'(ref_out[i]));
    end

    // Asynchronous reset mid-cycle, then release without an edge
    step(1'b1);
    chk("pre_async", 32'(bus3.out), 32'(2'b11));
    #2;
    reset = 1'b0;
    hist  = '0;
    #1;
    chk("async_out_k3", 32'(bus3.out), 32'd0);
    chk("async_sr_k3",  32'(u_k3.sr),  32'd0);
    chk("async_out_k4", 32'(bus4.out), 32'd0);
    chk("async_sr_k4",  32'(u_k4.sr),  32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("release_hold", 32'(bus3.out), 32'd0);

    // All-zero input
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      chk($sformatf("zero_%0d", i), 32'(bus3.out), 32'd0);
    end

    // Impulse response
    for (int i = 0; i < 5; i++) begin
      step(imp_in[i]);
      chk($sformatf("imp_%0d", i), 32'(bus3.out), 32'(imp_out[i]));
    end

    // Mid-stream reset clears memory: expect 11, not 10
    step(1'b1);
    chk("mid_a", 32'(bus3.out), 32'(2'b11));
    step(1'b1);
    chk("mid_b", 32'(bus3.out), 32'(2'b01));
    #2;
    reset = 1'b0;
    hist  = '0;
    #2;
    reset = 1'b1;
    step(1'b1);
    chk("mid_after_rst", 32'(bus3.out), 32'(2'b11));

    // Random stream against the behavioural model, both configurations
    for (int i = 0; i < 1000; i++) begin
      rb = 1'($urandom_range(0, 1));
      step(rb);
      chk($sformatf("rnd_k3_%0d", i), 32'(bus3.out), 32'(model(3, 9'b111, 9'b101, hist)));
    end

    // Flush returns the memory to zero
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("flush_sr_k3", 32'(u_k3.sr), 32'd0);
    chk("flush_sr_k4", 32'(u_k4.sr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
